// File: rtl/hs_cdc_tx_if.sv
// Source-side handshake bundle for hs_cdc_tx: local word/valid/ready,
// the REQ/REQ_DATA/ACK crossing and the DONE/OVERRUN status pulses.
interface hs_cdc_tx_if #(
  parameter int unsigned BUS_WIDTH = 8
) ();
  logic [BUS_WIDTH-1:0] TX_DATA;
  logic                 TX_VALID;
  logic                 TX_READY;
  logic                 REQ;
  logic [BUS_WIDTH-1:0] REQ_DATA;
  logic                 ACK;
  logic                 DONE;
  logic                 OVERRUN;

  modport master (
    output TX_DATA, TX_VALID, ACK,
    input  TX_READY, REQ, REQ_DATA, DONE, OVERRUN
  );

  modport slave (
    input  TX_DATA, TX_VALID, ACK,
    output TX_READY, REQ, REQ_DATA, DONE, OVERRUN
  );
endinterface

// File: rtl/hs_cdc_tx.sv
// Source-domain half of a 4-phase req/ack CDC handshake: holds a word on
// REQ_DATA under REQ and completes once the synchronized ACK has risen and fallen.
module hs_cdc_tx #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  hs_cdc_tx_if.slave bus
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("hs_cdc_tx: NUM_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_STAGES-1:0]  ack_sync_q, ack_sync_d;
  logic                   ack_s;
  logic                   tx_ready;
  logic                   req_q, req_d;
  logic [BUS_WIDTH-1:0]   req_data_q, req_data_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;

  // ACK is asynchronous; only the last chain stage may steer the FSM.
  assign ack_sync_d = {ack_sync_q[NUM_STAGES-2:0], bus.ACK};
  assign ack_s      = ack_sync_q[NUM_STAGES-1];
  assign tx_ready   = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    req_data_d = req_data_q;
    done_d     = 1'b0;
    overrun_d  = bus.TX_VALID && !tx_ready;
    unique case (state_q)
      IDLE: begin
        if (bus.TX_VALID && tx_ready) begin
          req_data_d = bus.TX_DATA;
          req_d      = 1'b1;
          state_d    = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LO;
        end
      end
      ACK_LO: begin
        // REQ_DATA stays frozen until the destination has released ACK.
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      req_q      <= 1'b0;
      req_data_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      req_q      <= req_d;
      req_data_q <= req_data_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.TX_READY = tx_ready;
  assign bus.REQ      = req_q;
  assign bus.REQ_DATA = req_data_q;
  assign bus.DONE     = done_q;
  assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_hs_cdc_tx.sv
// Bench for hs_cdc_tx: directed handshake scenarios plus a randomized run
// against a transaction-level model of the source side.
module tb_hs_cdc_tx;
  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  hs_cdc_tx_if #(.BUS_WIDTH(W)) bus  ();
  hs_cdc_tx_if #(.BUS_WIDTH(W)) bus3 ();

  hs_cdc_tx #(.NUM_STAGES(2), .BUS_WIDTH(W)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  hs_cdc_tx #(.NUM_STAGES(3), .BUS_WIDTH(W)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

  int checks = 0;
  int errors = 0;

  // Model: one outstanding word, whether ACK has been seen high for it,
  // and the last two sampled ACK values (oldest = what the block reacts to).
  bit             ackq[$];
  bit             m_busy, m_seen, m_done, m_ovr;
  logic [W-1:0]   m_word;

  function automatic bit m_ready();
    return !m_busy && !ackq[0];
  endfunction

  function automatic bit m_req();
    return m_busy && !m_seen;
  endfunction

  function automatic void model_step(input logic r, input logic v,
                                     input logic [W-1:0] d, input logic a);
    bit acks;
    bit rdy;
    if (!r) begin
      m_busy = 0; m_seen = 0; m_done = 0; m_ovr = 0; m_word = '0;
      ackq.delete();
      ackq.push_back(1'b0);
      ackq.push_back(1'b0);
    end else begin
      acks   = ackq[0];
      rdy    = !m_busy && !acks;
      m_done = 0;
      m_ovr  = v && !rdy;
      if (!m_busy) begin
        if (v && rdy) begin
          m_word = d; m_busy = 1; m_seen = 0;
        end
      end else if (!m_seen) begin
        if (acks) m_seen = 1;
      end else if (!acks) begin
        m_busy = 0; m_done = 1;
      end
      ackq.push_back(a);
      void'(ackq.pop_front());
    end
  endfunction

  task automatic tick();
    logic r, v, a;
    logic [W-1:0] d;
    @(posedge CLK);
    r = RST; v = bus.TX_VALID; a = bus.ACK; d = bus.TX_DATA;
    model_step(r, v, d, a);
    #1;
  endtask

  task automatic finish_xfer(output bit ok);
    bus.ACK = 1'b1;
    for (int i = 0; i < 20 && bus.REQ !== 1'b0; i++) tick();
    bus.ACK = 1'b0;
    if (bus.REQ === 1'b0)
      for (int i = 0; i < 20 && bus.DONE !== 1'b1; i++) tick();
    ok = (bus.REQ === 1'b0) && (bus.DONE === 1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b0; bus.TX_VALID = 1'b1; bus.ACK = 1'b1; bus.TX_DATA = 8'h5A;
    tick(); tick();
    checks++; if (bus.REQ !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.REQ); end
    checks++; if (bus.REQ_DATA !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", bus.REQ_DATA); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.DONE); end
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", bus.OVERRUN); end
    RST = 1'b1; bus.TX_VALID = 1'b0;
    repeat (3) tick();
    checks++; if (bus.TX_READY !== 1'b0) begin errors++; $display("FAIL rst_ready_ackhi got %b exp 0", bus.TX_READY); end
    bus.ACK = 1'b0;
    tick();
    checks++; if (bus.TX_READY !== 1'b0) begin errors++; $display("FAIL rst_ready_lag got %b exp 0", bus.TX_READY); end
    tick();
    checks++; if (bus.TX_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_free got %b exp 1", bus.TX_READY); end
    checks++; if (bus.REQ !== 1'b0) begin errors++; $display("FAIL rst_no_req got %b exp 0", bus.REQ); end
  endtask

  task automatic test_single();
    bus.TX_DATA = 8'hA5; bus.TX_VALID = 1'b1;
    tick();
    bus.TX_VALID = 1'b0; bus.TX_DATA = 8'($urandom);
    checks++; if (bus.REQ !== 1'b1) begin errors++; $display("FAIL single_req got %b exp 1", bus.REQ); end
    checks++; if (bus.REQ_DATA !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", bus.REQ_DATA); end
    bus.ACK = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.REQ !== 1'(i < 3)) begin errors++; $display("FAIL single_req_fall[%0d] got %b exp %b", i, bus.REQ, i < 3); end
      checks++; if (bus.REQ_DATA !== 8'hA5) begin errors++; $display("FAIL single_hold_hi[%0d] got %h exp a5", i, bus.REQ_DATA); end
    end
    bus.ACK = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.DONE !== 1'(i == 3)) begin errors++; $display("FAIL single_done[%0d] got %b exp %b", i, bus.DONE, i == 3); end
      checks++; if (bus.REQ_DATA !== 8'hA5) begin errors++; $display("FAIL single_hold_lo[%0d] got %h exp a5", i, bus.REQ_DATA); end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    bus.TX_DATA = 8'hA5; bus.TX_VALID = 1'b1;
    tick();
    bus.TX_DATA = 8'h3C;
    tick();
    bus.TX_VALID = 1'b0;
    checks++; if (bus.OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", bus.OVERRUN); end
    checks++; if (bus.REQ_DATA !== 8'hA5) begin errors++; $display("FAIL ovr_data got %h exp a5", bus.REQ_DATA); end
    tick();
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", bus.OVERRUN); end
    checks++; if (bus.REQ !== 1'b1) begin errors++; $display("FAIL ovr_req_held got %b exp 1", bus.REQ); end
    finish_xfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_complete got req=%b done=%b exp 0/1", bus.REQ, bus.DONE); end
    checks++; if (bus.REQ_DATA !== 8'hA5) begin errors++; $display("FAIL ovr_final_data got %h exp a5", bus.REQ_DATA); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.TX_DATA = 8'h01; bus.TX_VALID = 1'b1;
    tick();
    checks++; if (bus.REQ_DATA !== 8'h01) begin errors++; $display("FAIL b2b_first got %h exp 01", bus.REQ_DATA); end
    bus.TX_DATA = 8'h02;
    finish_xfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done1 got req=%b done=%b exp 0/1", bus.REQ, bus.DONE); end
    checks++; if (bus.TX_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b exp 1", bus.TX_READY); end
    tick();
    bus.TX_VALID = 1'b0;
    checks++; if (bus.REQ !== 1'b1) begin errors++; $display("FAIL b2b_req2 got %b exp 1", bus.REQ); end
    checks++; if (bus.REQ_DATA !== 8'h02) begin errors++; $display("FAIL b2b_data2 got %h exp 02", bus.REQ_DATA); end
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got %b exp 0", bus.OVERRUN); end
    finish_xfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done2 got req=%b done=%b exp 0/1", bus.REQ, bus.DONE); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.TX_DATA = 8'h77; bus.TX_VALID = 1'b1;
    tick();
    bus.TX_VALID = 1'b0; bus.ACK = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    checks++; if (bus.REQ !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", bus.REQ); end
    checks++; if (bus.REQ_DATA !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", bus.REQ_DATA); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", bus.DONE); end
    RST = 1'b1; bus.ACK = 1'b0;
    tick(); tick();
    checks++; if (bus.TX_READY !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.TX_READY); end
    bus.TX_DATA = 8'hFF; bus.TX_VALID = 1'b1;
    tick();
    bus.TX_VALID = 1'b0;
    checks++; if (bus.REQ_DATA !== 8'hFF) begin errors++; $display("FAIL mid_new_data got %h exp ff", bus.REQ_DATA); end
    finish_xfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_new_done got req=%b done=%b exp 0/1", bus.REQ, bus.DONE); end
    tick();
  endtask

  task automatic test_glitch();
    bit ok;
    logic [W-1:0] g;
    g = 8'($urandom);
    bus.TX_DATA = g; bus.TX_VALID = 1'b1;
    tick();
    bus.TX_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 bus.ACK = 1'b1;
      #4 bus.ACK = 1'b0;
      tick();
      checks++; if (bus.REQ !== 1'b1) begin errors++; $display("FAIL glitch_req[%0d] got %b exp 1", i, bus.REQ); end
      checks++; if (bus.REQ_DATA !== g) begin errors++; $display("FAIL glitch_data[%0d] got %h exp %h", i, bus.REQ_DATA, g); end
    end
    finish_xfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_complete got req=%b done=%b exp 0/1", bus.REQ, bus.DONE); end
    tick();
    bus3.TX_DATA = 8'hC3; bus3.TX_VALID = 1'b1;
    tick();
    bus3.TX_VALID = 1'b0;
    checks++; if (bus3.REQ !== 1'b1) begin errors++; $display("FAIL lag3_req got %b exp 1", bus3.REQ); end
    bus3.ACK = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus3.REQ !== 1'(i < 4)) begin errors++; $display("FAIL lag3_req_fall[%0d] got %b exp %b", i, bus3.REQ, i < 4); end
    end
    bus3.ACK = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (bus3.DONE !== 1'(i == 4)) begin errors++; $display("FAIL lag3_done[%0d] got %b exp %b", i, bus3.DONE, i == 4); end
    end
    checks++; if (bus3.REQ_DATA !== 8'hC3) begin errors++; $display("FAIL lag3_data got %h exp c3", bus3.REQ_DATA); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 99) != 0);
      bus.TX_VALID = ($urandom_range(0, 2) == 0);
      bus.TX_DATA = 8'($urandom);
      if (bus.ACK !== bus.REQ && $urandom_range(0, 2) == 0) bus.ACK = bus.REQ;
      else if ($urandom_range(0, 49) == 0) bus.ACK = ~bus.ACK;
      tick();
      checks++; if (bus.REQ !== m_req()) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", c, bus.REQ, m_req()); end
      checks++; if (bus.REQ_DATA !== m_word) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", c, bus.REQ_DATA, m_word); end
      checks++; if (bus.DONE !== m_done) begin errors++; $display("FAIL rnd_done[%0d] got %b exp %b", c, bus.DONE, m_done); end
      checks++; if (bus.OVERRUN !== m_ovr) begin errors++; $display("FAIL rnd_ovr[%0d] got %b exp %b", c, bus.OVERRUN, m_ovr); end
      checks++; if (bus.TX_READY !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, bus.TX_READY, m_ready()); end
    end
    RST = 1'b1; bus.TX_VALID = 1'b0;
  endtask

  initial begin
    bus.TX_DATA = '0; bus.TX_VALID = 1'b0; bus.ACK = 1'b0;
    bus3.TX_DATA = '0; bus3.TX_VALID = 1'b0; bus3.ACK = 1'b0;
    model_step(1'b0, 1'b0, '0, 1'b0);
    test_reset();
    test_single();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
